// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between the workout state machine (master) and the
// interval timer (slave).
interface interval_timer_ctrl_if #(
    parameter int SEC_W = 8
);
    logic             start_timer;
    logic [1:0]       phase;
    logic [SEC_W-1:0] work_secs;
    logic [SEC_W-1:0] rest_secs;
    logic             pause;
    logic             time_done;
    logic             sec_tick;
    logic [SEC_W-1:0] secs_left;
    logic             running;
    logic             warn;

    modport master (
        output start_timer, phase, work_secs, rest_secs, pause,
        input  time_done, sec_tick, secs_left, running, warn
    );

    modport slave (
        input  start_timer, phase, work_secs, rest_secs, pause,
        output time_done, sec_tick, secs_left, running, warn
    );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Interval countdown for the workout sequencer: loads the phase's duration,
// prescales clk to 1 s ticks, supports pause/skip/abort and pulses on expiry.
module interval_timer_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int SEC_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    interval_timer_ctrl_if.slave tmr
);
    localparam int               PRE_W   = $clog2(TICKS_PER_SEC);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [1:0]       PH_WORK = 2'b01;
    localparam logic [1:0]       PH_REST = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSED,
        S_EXPIRED
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [SEC_W-1:0] secs_q, secs_d;
    logic [1:0]       phase_q, phase_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;
    logic             phase_valid;
    logic             active;
    logic [SEC_W-1:0] load_val;

    function automatic logic [SEC_W-1:0] sat_dec(input logic [SEC_W-1:0] v);
        return (v == '0) ? '0 : v - SEC_W'(1);
    endfunction

    assign phase_valid = (tmr.phase == PH_WORK) || (tmr.phase == PH_REST);
    assign load_val    = (tmr.phase == PH_WORK) ? tmr.work_secs : tmr.rest_secs;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        secs_d  = secs_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        tick_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                secs_d = '0;
                if (tmr.start_timer && phase_valid) state_d = S_LOAD;
            end
            S_LOAD: begin
                phase_d = tmr.phase;
                secs_d  = load_val;
                presc_d = '0;
                if (load_val == '0) begin
                    state_d = S_EXPIRED;
                    done_d  = 1'b1;
                end else if (tmr.pause) begin
                    state_d = S_PAUSED;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_PAUSED: begin
                // A PAUSED cycle with pause released counts like RUN, so the
                // countdown only stalls for cycles where pause is actually high.
                if (!tmr.start_timer) begin
                    state_d = S_IDLE;
                    secs_d  = '0;
                end else if (tmr.phase != phase_q) begin
                    state_d = S_LOAD;
                end else if (tmr.pause) begin
                    state_d = S_PAUSED;
                end else begin
                    state_d = S_RUN;
                    if (presc_q == PRE_MAX) begin
                        presc_d = '0;
                        tick_d  = (secs_q != '0);
                        secs_d  = sat_dec(secs_q);
                        if (secs_q <= SEC_W'(1)) begin
                            state_d = S_EXPIRED;
                            done_d  = (secs_q == SEC_W'(1));
                        end
                    end else begin
                        presc_d = presc_q + PRE_W'(1);
                    end
                end
            end
            S_EXPIRED: begin
                secs_d = '0;
                if (!tmr.start_timer || !phase_valid) state_d = S_IDLE;
                else if (tmr.phase != phase_q)       state_d = S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
                secs_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            secs_q  <= '0;
            phase_q <= '0;
            done_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            secs_q  <= secs_d;
            phase_q <= phase_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
        end
    end

    assign active        = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign tmr.running   = active;
    assign tmr.warn      = active && (secs_q != '0) && (secs_q <= SEC_W'(3));
    assign tmr.time_done = done_q;
    assign tmr.sec_tick  = tick_q;
    assign tmr.secs_left = secs_q;
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl with a 4-cycle second.
module tb_interval_timer_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;
    int   at;
    int   ticks;

    interval_timer_ctrl_if #(.SEC_W(8)) tmr ();

    interval_timer_ctrl #(.TICKS_PER_SEC(4), .SEC_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tmr     (tmr)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk_s({tag, "_secs"},    tmr.secs_left, 8'd0);
        chk_b({tag, "_running"}, tmr.running,   1'b0);
        chk_b({tag, "_warn"},    tmr.warn,      1'b0);
        chk_b({tag, "_done"},    tmr.time_done, 1'b0);
        chk_b({tag, "_tick"},    tmr.sec_tick,  1'b0);
    endtask

    // Returns the cycle index (1-based) at which time_done is seen, or -1.
    task automatic wait_done(input int limit, output int at_o, output int ticks_o);
        at_o    = -1;
        ticks_o = 0;
        for (int i = 1; i <= limit; i++) begin
            cyc(1);
            if (tmr.sec_tick) ticks_o++;
            if (tmr.time_done) begin
                at_o = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        tmr.start_timer = 1'b0;
        tmr.phase       = 2'b00;
        tmr.work_secs   = 8'd3;
        tmr.rest_secs   = 8'd2;
        tmr.pause       = 1'b0;
        cyc(3);
        chk_idle("reset");
        reset_n = 1'b1;
        cyc(2);
        chk_idle("post_reset");

        // Invalid phase code never leaves IDLE
        tmr.phase       = 2'b11;
        tmr.start_timer = 1'b1;
        cyc(3);
        chk_b("inv_phase_running", tmr.running, 1'b0);
        chk_s("inv_phase_secs", tmr.secs_left, 8'd0);

        // Case 1: 3 s workout
        tmr.phase = 2'b01;
        cyc(1);
        chk_b("t1_load_running", tmr.running, 1'b0);
        cyc(1);
        chk_s("t1_run_secs", tmr.secs_left, 8'd3);
        chk_b("t1_run_running", tmr.running, 1'b1);
        chk_b("t1_run_warn", tmr.warn, 1'b1);
        tmr.work_secs = 8'd7;
        wait_done(20, at, ticks);
        chk_i("t1_done_at", at, 12);
        chk_i("t1_ticks", ticks, 3);
        chk_s("t1_done_secs", tmr.secs_left, 8'd0);
        chk_b("t1_done_running", tmr.running, 1'b0);
        chk_b("t1_done_warn", tmr.warn, 1'b0);
        tmr.work_secs = 8'd3;
        cyc(1);
        chk_b("t1_no_repeat", tmr.time_done, 1'b0);

        // Case 2: switch to rest after expiry
        tmr.phase = 2'b10;
        cyc(1);
        chk_b("t2_load_running", tmr.running, 1'b0);
        cyc(1);
        chk_s("t2_run_secs", tmr.secs_left, 8'd2);
        chk_b("t2_run_warn", tmr.warn, 1'b1);
        wait_done(20, at, ticks);
        chk_i("t2_done_at", at, 8);
        chk_i("t2_ticks", ticks, 2);

        // Case 3: 5-cycle pause mid-interval
        tmr.phase = 2'b01;
        cyc(2);
        chk_s("t3_run_secs", tmr.secs_left, 8'd3);
        cyc(5);
        chk_s("t3_mid_secs", tmr.secs_left, 8'd2);
        tmr.pause = 1'b1;
        cyc(1);
        chk_b("t3_paused_running", tmr.running, 1'b1);
        chk_s("t3_paused_secs", tmr.secs_left, 8'd2);
        cyc(4);
        chk_s("t3_frozen_secs", tmr.secs_left, 8'd2);
        chk_b("t3_frozen_tick", tmr.sec_tick, 1'b0);
        chk_b("t3_frozen_warn", tmr.warn, 1'b1);
        tmr.pause = 1'b0;
        wait_done(20, at, ticks);
        chk_i("t3_done_at", at, 7);
        chk_i("t3_ticks", ticks, 2);

        // Case 4: skip from workout to rest while counting
        tmr.start_timer = 1'b0;
        cyc(1);
        chk_idle("t4_idle");
        tmr.start_timer = 1'b1;
        cyc(2);
        chk_s("t4_run_secs", tmr.secs_left, 8'd3);
        cyc(5);
        chk_s("t4_mid_secs", tmr.secs_left, 8'd2);
        tmr.phase     = 2'b10;
        tmr.rest_secs = 8'd5;
        cyc(1);
        chk_b("t4_load_running", tmr.running, 1'b0);
        chk_b("t4_load_done", tmr.time_done, 1'b0);
        cyc(1);
        chk_s("t4_reload_secs", tmr.secs_left, 8'd5);
        chk_b("t4_reload_warn", tmr.warn, 1'b0);
        chk_b("t4_reload_running", tmr.running, 1'b1);
        wait_done(30, at, ticks);
        chk_i("t4_done_at", at, 20);
        chk_i("t4_ticks", ticks, 5);

        // Case 5a: start_timer drops mid-RUN
        tmr.phase = 2'b01;
        cyc(2);
        chk_s("t5a_run_secs", tmr.secs_left, 8'd3);
        cyc(2);
        tmr.start_timer = 1'b0;
        cyc(1);
        chk_idle("t5a_drop");
        wait_done(8, at, ticks);
        chk_i("t5a_no_done", at, -1);

        // Case 5b: asynchronous reset mid-RUN
        tmr.start_timer = 1'b1;
        cyc(2);
        chk_b("t5b_run_running", tmr.running, 1'b1);
        cyc(3);
        reset_n = 1'b0;
        #1;
        chk_idle("t5b_async");
        cyc(2);
        chk_idle("t5b_held");
        reset_n = 1'b1;
        cyc(1);
        chk_b("t5b_release_done", tmr.time_done, 1'b0);
        chk_b("t5b_release_tick", tmr.sec_tick, 1'b0);
        chk_b("t5b_release_running", tmr.running, 1'b0);
        cyc(1);
        chk_s("t5b_rerun_secs", tmr.secs_left, 8'd3);

        // Case 6: zero-length interval
        tmr.start_timer = 1'b0;
        cyc(1);
        tmr.work_secs   = 8'd0;
        tmr.start_timer = 1'b1;
        cyc(1);
        chk_b("t6_load_done", tmr.time_done, 1'b0);
        cyc(1);
        chk_b("t6_done", tmr.time_done, 1'b1);
        chk_s("t6_secs", tmr.secs_left, 8'd0);
        chk_b("t6_running", tmr.running, 1'b0);
        chk_b("t6_tick", tmr.sec_tick, 1'b0);
        wait_done(10, at, ticks);
        chk_i("t6_no_repeat", at, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
